// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL retune sequencer: FSM encodings, reconfig-core
// register map and the PAL/NTSC counter profiles.
package pll_reconfig_pkg;

  localparam int PROFILE_LEN = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR        = 3'd1;
  localparam state_t ST_POLL_GAP  = 3'd2;
  localparam state_t ST_POLL_RD   = 3'd3;
  localparam state_t ST_LOCK_WAIT = 3'd4;
  localparam state_t ST_DONE      = 3'd5;
  localparam state_t ST_ERR       = 3'd6;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C      = 6'd5;
  localparam logic [5:0] ADDR_K      = 6'd7;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } profile_entry_t;

  typedef profile_entry_t [PROFILE_LEN-1:0] profile_t;

  // Entry 0 is the rightmost element; START must stay last.
  localparam profile_t PROFILE_PAL = {
    {ADDR_START, 32'd1},
    {ADDR_C,     32'h0000_0606},
    {ADDR_K,     32'd2201370713},
    {ADDR_M,     32'h0000_0404},
    {ADDR_N,     32'h0001_0000},
    {ADDR_MODE,  32'd1}
  };

  localparam profile_t PROFILE_NTSC = {
    {ADDR_START, 32'd1},
    {ADDR_C,     32'h0000_0606},
    {ADDR_K,     32'd3670244780},
    {ADDR_M,     32'h0002_0403},
    {ADDR_N,     32'h0001_0000},
    {ADDR_MODE,  32'd1}
  };

  // Indexed by mode: 0 = PAL, 1 = NTSC.
  localparam profile_t [1:0] PROFILE = {PROFILE_NTSC, PROFILE_PAL};

endpackage

// File: rtl/pll_reconfig_seq_sync2.sv
// Two-flop synchroniser for slow asynchronous level inputs.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Retunes the PLL between PAL and NTSC through the reconfig core's Avalon-MM
// management port; force_req carries the single-cycle reapply pulse.
//
// state        | meaning
// IDLE         | waiting for a pending request
// WR           | writing profile entries 0..5 (last one is START)
// POLL_GAP     | idle gap between STATUS reads
// POLL_RD      | reading STATUS, bit0 = reconfig finished
// LOCK_WAIT    | waiting for 4 consecutive locked cycles
// DONE         | commit active_mode, pulse done
// ERR          | timeout, set sticky error
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned POLL_GAP       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_sel,
  input  logic        force_req,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        active_mode,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LOAD   = 16'(POLL_GAP - 1);
  localparam logic [2:0]  LAST_IDX   = 3'(PROFILE_LEN - 1);

  logic           mode_sync, locked_sync, mode_prev;
  logic           pending, target;
  state_t         state;
  logic [2:0]     idx, idx_next;
  logic [15:0]    to_cnt, gap_cnt;
  logic [1:0]     lock_cnt;
  logic           accept, wr_ack, rd_ack, timed_out, guarded;
  profile_entry_t first_entry, next_entry;
  logic           unused_readdata;

  sync2 u_sync_mode   (.clk(clk), .rst_n(rst_n), .d(mode_sel),   .q(mode_sync));
  sync2 u_sync_locked (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(locked_sync));

  assign accept      = (state == ST_IDLE) && pending;
  assign wr_ack      = mgmt_write && !mgmt_waitrequest;
  assign rd_ack      = mgmt_read && !mgmt_waitrequest;
  assign timed_out   = (to_cnt == TIMEOUT_TC);
  assign guarded     = (state == ST_POLL_GAP) || (state == ST_POLL_RD) || (state == ST_LOCK_WAIT);
  assign idx_next    = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  assign first_entry = PROFILE[mode_sync][0];
  assign next_entry  = PROFILE[target][idx_next];
  assign unused_readdata = ^mgmt_readdata[31:1];

  // A mode change and force in the same cycle still make a single request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev <= 1'b0;
      pending   <= 1'b0;
    end else begin
      mode_prev <= mode_sync;
      pending   <= (pending && !accept) || (mode_sync ^ mode_prev) || force_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= 3'd0;
      target         <= 1'b0;
      to_cnt         <= 16'd0;
      gap_cnt        <= 16'd0;
      lock_cnt       <= 2'd0;
      mgmt_address   <= 6'd0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_writedata <= 32'd0;
      busy           <= 1'b0;
      active_mode    <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (guarded && to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          busy <= pending;
          if (pending) begin
            target         <= mode_sync;
            idx            <= 3'd0;
            mgmt_write     <= 1'b1;
            mgmt_address   <= first_entry.addr;
            mgmt_writedata <= first_entry.data;
            state          <= ST_WR;
          end
        end
        ST_WR: begin
          if (wr_ack) begin
            if (idx == LAST_IDX) begin
              mgmt_write     <= 1'b0;
              mgmt_address   <= 6'd0;
              mgmt_writedata <= 32'd0;
              to_cnt         <= 16'd0;
              gap_cnt        <= GAP_LOAD;
              state          <= ST_POLL_GAP;
            end else begin
              idx            <= idx_next;
              mgmt_address   <= next_entry.addr;
              mgmt_writedata <= next_entry.data;
            end
          end
        end
        ST_POLL_GAP: begin
          if (timed_out) begin
            state <= ST_ERR;
          end else if (gap_cnt == 16'd0) begin
            mgmt_read    <= 1'b1;
            mgmt_address <= ADDR_STATUS;
            state        <= ST_POLL_RD;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        ST_POLL_RD: begin
          if (timed_out) begin
            mgmt_read    <= 1'b0;
            mgmt_address <= 6'd0;
            state        <= ST_ERR;
          end else if (rd_ack) begin
            mgmt_read    <= 1'b0;
            mgmt_address <= 6'd0;
            if (mgmt_readdata[0]) begin
              to_cnt   <= 16'd0;
              lock_cnt <= 2'd3;
              state    <= ST_LOCK_WAIT;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_POLL_GAP;
            end
          end
        end
        ST_LOCK_WAIT: begin
          if (timed_out) begin
            state <= ST_ERR;
          end else if (!locked_sync) begin
            lock_cnt <= 2'd3;
          end else if (lock_cnt == 2'd0) begin
            state <= ST_DONE;
          end else begin
            lock_cnt <= lock_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          active_mode <= target;
          error       <= 1'b0;
          done        <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_ERR: begin
          error <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: Avalon BFM with a write scoreboard plus
// per-scenario tasks checking timing, status polling, timeout and force.
module tb_pll_reconfig_seq;

  logic        clk = 1'b0;
  logic        rst_n, mode_sel, force_req, pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        busy, active_mode, done, error;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [37:0] exp_q[$];
  int   wait_per_write = 0;
  int   status_ok_on = 1;
  int   seq_reads = 0;
  int   read_count = 0;
  int   bus_cycles = 0;
  int   wait_cnt = 0;
  bit   wr_active = 0;
  int   wr_start = 0;
  int   wr_end = 0;
  logic busy_at_start = 1'b0;
  logic [5:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;

  pll_reconfig_seq #(.TIMEOUT_CYCLES(200), .POLL_GAP(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .force_req(force_req),
    .pll_locked(pll_locked), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_read(mgmt_read), .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .busy(busy), .active_mode(active_mode),
    .done(done), .error(error)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [37:0] prof(input logic ntsc, input int i);
    case (i)
      0: return {6'd0, 32'd1};
      1: return {6'd3, 32'h0001_0000};
      2: return ntsc ? {6'd4, 32'h0002_0403} : {6'd4, 32'h0000_0404};
      3: return ntsc ? {6'd7, 32'd3670244780} : {6'd7, 32'd2201370713};
      4: return {6'd5, 32'h0000_0606};
      default: return {6'd2, 32'd1};
    endcase
  endfunction

  task automatic push_profile(input logic ntsc);
    for (int i = 0; i < 6; i++) exp_q.push_back(prof(ntsc, i));
  endtask

  // Avalon slave: decides waitrequest/readdata each cycle and scores completed writes.
  initial begin
    logic [37:0] exp;
    mgmt_waitrequest = 1'b0;
    mgmt_readdata = 32'd0;
    forever begin
      @(negedge clk);
      mgmt_waitrequest = 1'b0;
      mgmt_readdata = 32'd0;
      if (mgmt_write || mgmt_read) bus_cycles++;
      if (mgmt_write) begin
        if (!wr_active) begin
          wr_active = 1;
          wr_start = cyc;
          busy_at_start = busy;
        end
        if (wait_cnt == 0) begin
          hold_addr = mgmt_address;
          hold_data = mgmt_writedata;
        end else begin
          tests_run++;
          if (mgmt_address !== hold_addr || mgmt_writedata !== hold_data) begin
            tests_failed++;
            $display("FAIL hold_stable: got addr %0d data 0x%08h, required addr %0d data 0x%08h",
                     mgmt_address, mgmt_writedata, hold_addr, hold_data);
          end
        end
        if (wait_cnt < wait_per_write) begin
          mgmt_waitrequest = 1'b1;
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL write_seq: got addr %0d data 0x%08h, required no write",
                     mgmt_address, mgmt_writedata);
          end else begin
            exp = exp_q.pop_front();
            if ({mgmt_address, mgmt_writedata} !== exp) begin
              tests_failed++;
              $display("FAIL write_seq: got addr %0d data 0x%08h, required addr %0d data 0x%08h",
                       mgmt_address, mgmt_writedata, exp[37:32], exp[31:0]);
            end
          end
          if (mgmt_address == 6'd2) begin
            wr_active = 0;
            wr_end = cyc;
            seq_reads = 0;
          end
        end
      end else if (mgmt_read) begin
        read_count++;
        seq_reads++;
        tests_run++;
        if (mgmt_address !== 6'd1) begin
          tests_failed++;
          $display("FAIL read_addr: got %0d, required 1", mgmt_address);
        end
        mgmt_readdata = (status_ok_on != 0 && seq_reads >= status_ok_on) ? 32'd1 : 32'd0;
      end
    end
  end

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check(input bit cond, input string name, input int got, input int req);
    tests_run++;
    if (!cond) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode_sel = 1'b0; force_req = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({mgmt_write, mgmt_read, mgmt_address, mgmt_writedata, busy, done, error, active_mode} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wr %b rd %b addr %0d data 0x%08h busy %b done %b err %b mode %b, required all 0",
               mgmt_write, mgmt_read, mgmt_address, mgmt_writedata, busy, done, error, active_mode);
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check(bus_cycles == 0, "reset_no_bus", bus_cycles, 0);
    check(active_mode === 1'b0, "reset_active_mode", int'(active_mode), 0);
    check(busy === 1'b0, "reset_busy", int'(busy), 0);
  endtask

  task automatic test_ntsc_switch;
    int c0;
    bit ok;
    wait_per_write = 0; status_ok_on = 3; read_count = 0;
    @(posedge clk); #1;
    push_profile(1'b1);
    mode_sel = 1'b1;
    c0 = cyc;
    wait_done(1000, ok);
    check(ok, "ntsc_done_seen", int'(ok), 1);
    check(active_mode === 1'b1, "ntsc_active_mode", int'(active_mode), 1);
    check(wr_start - c0 == 4, "ntsc_req_latency", wr_start - c0, 4);
    check(busy_at_start === 1'b1, "ntsc_busy_rise", int'(busy_at_start), 1);
    check(wr_end - wr_start + 1 == 6, "ntsc_wr_cycles", wr_end - wr_start + 1, 6);
    check(read_count == 3, "ntsc_status_reads", read_count, 3);
    check(exp_q.size() == 0, "ntsc_writes_left", exp_q.size(), 0);
    @(negedge clk);
    check(done === 1'b0, "ntsc_done_width", int'(done), 0);
    check(busy === 1'b0, "ntsc_busy_fall", int'(busy), 0);
  endtask

  task automatic test_waitrequest;
    bit ok;
    wait_per_write = 3; status_ok_on = 1; read_count = 0;
    @(negedge clk);
    push_profile(1'b0);
    mode_sel = 1'b0;
    wait_done(1000, ok);
    check(ok, "wait_done_seen", int'(ok), 1);
    check(wr_end - wr_start + 1 == 24, "wait_wr_cycles", wr_end - wr_start + 1, 24);
    check(active_mode === 1'b0, "wait_active_mode", int'(active_mode), 0);
    check(read_count == 1, "wait_status_reads", read_count, 1);
    check(exp_q.size() == 0, "wait_writes_left", exp_q.size(), 0);
    wait_per_write = 0;
  endtask

  task automatic test_back_to_back;
    bit seen;
    int pulses;
    logic first_mode;
    status_ok_on = 1; wait_per_write = 0;
    @(negedge clk);
    push_profile(1'b1);
    mode_sel = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mgmt_write === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check(seen, "b2b_first_write", int'(seen), 1);
    push_profile(1'b0);
    mode_sel = 1'b0;
    pulses = 0;
    first_mode = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (pulses == 0) first_mode = active_mode;
        pulses++;
      end
    end
    check(pulses == 2, "b2b_done_pulses", pulses, 2);
    check(first_mode === 1'b1, "b2b_first_mode", int'(first_mode), 1);
    check(active_mode === 1'b0, "b2b_final_mode", int'(active_mode), 0);
    check(busy === 1'b0, "b2b_busy_idle", int'(busy), 0);
    check(exp_q.size() == 0, "b2b_writes_left", exp_q.size(), 0);
  endtask

  task automatic test_timeout;
    bit ok;
    int diff;
    int pulses;
    status_ok_on = 0;
    @(negedge clk);
    push_profile(1'b1);
    mode_sel = 1'b1;
    ok = 0; diff = 0; pulses = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (error === 1'b1) begin
        ok = 1;
        diff = cyc - wr_end;
        break;
      end
    end
    check(ok, "timeout_error_set", int'(ok), 1);
    check(diff >= 200 && diff <= 218, "timeout_latency", diff, 218);
    check(pulses == 0, "timeout_no_done", pulses, 0);
    check(active_mode === 1'b0, "timeout_active_mode", int'(active_mode), 0);
    @(negedge clk);
    check(busy === 1'b0, "timeout_busy_fall", int'(busy), 0);
    check(exp_q.size() == 0, "timeout_writes_left", exp_q.size(), 0);
    // A second failing retune back to PAL leaves error set for the force scenario.
    push_profile(1'b0);
    mode_sel = 1'b0;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check(ok, "timeout2_busy_rise", int'(ok), 1);
    ok = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check(ok, "timeout2_busy_fall", int'(ok), 1);
    check(error === 1'b1, "timeout2_error", int'(error), 1);
  endtask

  task automatic test_force;
    bit ok;
    status_ok_on = 1; read_count = 0;
    check(error === 1'b1, "force_error_before", int'(error), 1);
    @(negedge clk);
    push_profile(1'b0);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    wait_done(1000, ok);
    check(ok, "force_done_seen", int'(ok), 1);
    check(error === 1'b0, "force_error_clear", int'(error), 0);
    check(active_mode === 1'b0, "force_active_mode", int'(active_mode), 0);
    check(read_count == 1, "force_status_reads", read_count, 1);
    repeat (60) @(negedge clk);
    check(exp_q.size() == 0, "force_writes_left", exp_q.size(), 0);
    check(busy === 1'b0, "force_busy_idle", int'(busy), 0);
  endtask

  initial begin
    test_reset();
    test_ntsc_switch();
    test_waitrequest();
    test_back_to_back();
    test_timeout();
    test_force();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
